// File: rtl/irq_pkg.sv
// Shared types and constants for the RISC-V interrupt controller.
package irq_pkg;

  localparam int IRQ_MAX         = 16;
  localparam int MCAUSE_IRQ_BASE = 16;
  localparam int IRQ_IDX_W       = $clog2(IRQ_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } irq_state_t;

  // Interrupt bit set, platform cause codes start at 16.
  function automatic logic [31:0] mcause_of(input logic [IRQ_IDX_W-1:0] idx);
    return {1'b1, 26'd0, 5'(MCAUSE_IRQ_BASE) + {1'b0, idx}};
  endfunction

endpackage

// File: rtl/riscv_irq_ctrl_if.sv
// Peripheral/core-facing signal bundle of the interrupt controller.
interface riscv_irq_ctrl_if #(
  parameter int N_IRQ = 16
);

  logic [N_IRQ-1:0] irq_i;
  logic [31:0]      mie_i;
  logic             int_rst_i;
  logic             int_o;
  logic [31:0]      mcause_o;
  logic [N_IRQ-1:0] irq_ack_o;

  modport master (
    output irq_i, mie_i, int_rst_i,
    input  int_o, mcause_o, irq_ack_o
  );

  modport slave (
    input  irq_i, mie_i, int_rst_i,
    output int_o, mcause_o, irq_ack_o
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational find-first-one starting at start_i, wrapping at N-1 -> 0.
module irq_prio_enc #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // rot[gi] is the request gi positions above start_i.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IW:0] src;
    always_comb begin
      src = {1'b0, start_i} + (IW+1)'(gi);
      if (src >= (IW+1)'(N)) src = src - (IW+1)'(N);
    end
    assign rot[gi] = req_i[src[IW-1:0]];
  end

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  always_comb begin
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
  end

  assign valid_o = |req_i;
  assign idx_o   = sum[IW-1:0];

endmodule

// File: rtl/riscv_irq_ctrl.sv
// Edge-capturing interrupt controller feeding the core's INT/mcause pins.
// Define IRQ_ROUND_ROBIN_EN for round-robin arbitration (default: lowest index wins).
module riscv_irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input logic             clk_i,
  input logic             arstn_i,
  riscv_irq_ctrl_if.slave bus
);

  logic [N_IRQ-1:0]     irq_q_reg;
  logic [N_IRQ-1:0]     pending_reg;
  logic [N_IRQ-1:0]     pending_next;
  logic [N_IRQ-1:0]     irq_edge;
  logic [N_IRQ-1:0]     eligible;
  logic [N_IRQ-1:0]     clr_mask;
  logic [N_IRQ-1:0]     ack_reg;
  irq_state_t           state_reg;
  logic [IRQ_IDX_W-1:0] idx_reg;
  logic [IRQ_IDX_W-1:0] start_idx;
  logic [IRQ_IDX_W-1:0] win_idx;
  logic                 win_valid;
  logic                 int_reg;
  logic [31:0]          mcause_reg;
  logic                 svc_done;

  assign irq_edge = bus.irq_i & ~irq_q_reg;
  assign eligible = pending_reg & bus.mie_i[N_IRQ-1:0];
  assign svc_done = (state_reg == BUSY) && bus.int_rst_i;

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_clr
    assign clr_mask[gi] = svc_done && (idx_reg == IRQ_IDX_W'(gi));
  end

  // A fresh edge on the line being cleared keeps it pending.
  assign pending_next = (pending_reg & ~clr_mask) | irq_edge;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IRQ_IDX_W-1:0] rr_ptr_reg;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rr_ptr_reg <= '0;
    end else if (svc_done) begin
      rr_ptr_reg <= (32'(idx_reg) == N_IRQ - 1) ? '0 : idx_reg + 1'b1;
    end
  end

  assign start_idx = rr_ptr_reg;
`else
  assign start_idx = '0;
`endif

  irq_prio_enc #(
    .N  (N_IRQ),
    .IW (IRQ_IDX_W)
  ) u_prio_enc (
    .req_i   (eligible),
    .start_i (start_idx),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      irq_q_reg   <= '0;
      pending_reg <= '0;
      state_reg   <= IDLE;
      idx_reg     <= '0;
      int_reg     <= 1'b0;
      mcause_reg  <= '0;
      ack_reg     <= '0;
    end else begin
      irq_q_reg   <= bus.irq_i;
      pending_reg <= pending_next;
      ack_reg     <= '0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            state_reg  <= BUSY;
            idx_reg    <= win_idx;
            int_reg    <= 1'b1;
            mcause_reg <= mcause_of(win_idx);
          end
        end
        BUSY: begin
          if (bus.int_rst_i) begin
            state_reg  <= IDLE;
            int_reg    <= 1'b0;
            mcause_reg <= '0;
            ack_reg    <= clr_mask;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.int_o     = int_reg;
  assign bus.mcause_o  = mcause_reg;
  assign bus.irq_ack_o = ack_reg;

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Directed and random checks of riscv_irq_ctrl against a cycle reference model.
// Honours IRQ_ROUND_ROBIN_EN the same way the design does.
module tb_riscv_irq_ctrl;

  localparam int N = 16;

  logic clk_i   = 1'b0;
  logic arstn_i = 1'b0;

  riscv_irq_ctrl_if #(.N_IRQ(N)) bus ();

  riscv_irq_ctrl #(.N_IRQ(N)) dut (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_pend [N];
  bit          m_prev [N];
  bit          m_busy;
  int          m_idx;
  int          m_rr;
  logic        exp_int;
  logic [31:0] exp_mcause;
  logic [N-1:0] exp_ack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 1'b0;
      m_prev[k] = 1'b0;
    end
    m_busy     = 1'b0;
    m_idx      = 0;
    m_rr       = 0;
    exp_int    = 1'b0;
    exp_mcause = '0;
    exp_ack    = '0;
  endtask

  // First pending and enabled line, searching upward from the pointer.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (m_pend[j] && bus.mie_i[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_clock();
    bit done;
    int old_idx;
    int w;
    done    = m_busy && bus.int_rst_i;
    old_idx = m_idx;
    exp_ack = '0;
    if (m_busy) begin
      if (bus.int_rst_i) begin
        m_busy     = 1'b0;
        exp_int    = 1'b0;
        exp_mcause = '0;
        exp_ack[old_idx] = 1'b1;
`ifdef IRQ_ROUND_ROBIN_EN
        m_rr = (old_idx + 1) % N;
`endif
      end
    end else begin
      w = pick();
      if (w >= 0) begin
        m_busy     = 1'b1;
        m_idx      = w;
        exp_int    = 1'b1;
        exp_mcause = 32'h8000_0000 | 32'(16 + w);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (done && k == old_idx) m_pend[k] = 1'b0;
      if (bus.irq_i[k] && !m_prev[k]) m_pend[k] = 1'b1;
      m_prev[k] = bus.irq_i[k];
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_clock();
    @(negedge clk_i);
    check_eq("int_o", 32'(bus.int_o), 32'(exp_int));
    check_eq("mcause_o", bus.mcause_o, exp_mcause);
    check_eq("irq_ack_o", 32'(bus.irq_ack_o), 32'(exp_ack));
    if (bus.irq_ack_o != '0) $display("ack 0x%04h at %0t", bus.irq_ack_o, $time);
  endtask

  task automatic do_reset();
    arstn_i       = 1'b0;
    bus.irq_i     = '0;
    bus.mie_i     = '0;
    bus.int_rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    model_reset();
    arstn_i = 1'b1;
  endtask

  task automatic ack_now();
    bus.int_rst_i = 1'b1;
    step();
    bus.int_rst_i = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40; t++) begin
      bus.int_rst_i = bus.int_o;
      step();
    end
    bus.int_rst_i = 1'b0;
  endtask

  int first_line;
  int second_line;
  int exp_line;

  initial begin
    bus.irq_i     = '0;
    bus.mie_i     = '0;
    bus.int_rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_int", 32'(bus.int_o), 32'd0);
    check_eq("rst_mcause", bus.mcause_o, 32'd0);
    check_eq("rst_ack", 32'(bus.irq_ack_o), 32'd0);
    check_eq("rst_pending", 32'(dut.pending_reg), 32'd0);
    model_reset();
    arstn_i = 1'b1;
    step();

    // Single source on line 5
    bus.mie_i = 32'h20;
    bus.irq_i = 16'h0020;
    step();
    bus.irq_i = '0;
    step();
    check_eq("single_int", 32'(bus.int_o), 32'd1);
    check_eq("single_mcause", bus.mcause_o, 32'h8000_0015);
    ack_now();
    check_eq("single_int_drop", 32'(bus.int_o), 32'd0);
    check_eq("single_ack", 32'(bus.irq_ack_o), 32'h0020);
    step();
    check_eq("single_ack_width", 32'(bus.irq_ack_o), 32'd0);
    $display("single source line 5 done");

    // Masked line stays pending
    bus.mie_i = '0;
    bus.irq_i = 16'h0004;
    step();
    bus.irq_i = '0;
    repeat (20) step();
    check_eq("mask_held", 32'(dut.pending_reg), 32'h0004);
    bus.mie_i = 32'h4;
    step();
    check_eq("mask_int", 32'(bus.int_o), 32'd1);
    check_eq("mask_mcause", bus.mcause_o, 32'h8000_0012);
    ack_now();
    step();
    $display("masking line 2 done");

    // Simultaneous edges on lines 1 and 7
`ifdef IRQ_ROUND_ROBIN_EN
    first_line  = 7;
    second_line = 1;
`else
    first_line  = 1;
    second_line = 7;
`endif
    bus.mie_i = 32'hFFFF;
    bus.irq_i = 16'h0082;
    step();
    bus.irq_i = '0;
    step();
    check_eq("prio_first", bus.mcause_o, 32'h8000_0010 + 32'(first_line));
    ack_now();
    check_eq("prio_gap", 32'(bus.int_o), 32'd0);
    step();
    check_eq("prio_second", bus.mcause_o, 32'h8000_0010 + 32'(second_line));
    ack_now();
    step();
    $display("priority lines 1/7 done");

    // Set/clear collision on line 6
    bus.irq_i = 16'h0040;
    step();
    bus.irq_i = '0;
    step();
    check_eq("coll_first", bus.mcause_o, 32'h8000_0016);
    bus.irq_i = 16'h0040;
    ack_now();
    check_eq("coll_ack", 32'(bus.irq_ack_o), 32'h0040);
    bus.irq_i = '0;
    step();
    check_eq("coll_reint", 32'(bus.int_o), 32'd1);
    check_eq("coll_remcause", bus.mcause_o, 32'h8000_0016);
    ack_now();
    step();
    $display("collision line 6 done");

    // Asynchronous reset while busy on line 3
    bus.irq_i = 16'h0008;
    step();
    bus.irq_i = '0;
    step();
    check_eq("arst_busy", bus.mcause_o, 32'h8000_0013);
    arstn_i = 1'b0;
    #1;
    check_eq("arst_int", 32'(bus.int_o), 32'd0);
    check_eq("arst_mcause", bus.mcause_o, 32'd0);
    check_eq("arst_pending", 32'(dut.pending_reg), 32'd0);
    repeat (2) @(negedge clk_i);
    model_reset();
    arstn_i = 1'b1;
    repeat (5) step();
    $display("reset mid-busy done");

    // Lines 0 and 4 re-edge after every ack
    bus.mie_i = 32'hFFFF;
    bus.irq_i = 16'h0011;
    step();
    bus.irq_i = '0;
    step();
    for (int i = 0; i < 4; i++) begin
`ifdef IRQ_ROUND_ROBIN_EN
      exp_line = (i % 2 == 0) ? 0 : 4;
`else
      exp_line = 0;
`endif
      check_eq("rr_order", bus.mcause_o, 32'h8000_0010 + 32'(exp_line));
      bus.irq_i = 16'(1 << exp_line);
      ack_now();
      bus.irq_i = '0;
      step();
    end
    drain();
    $display("re-edge 0/4 done");

    // Pointer wrap: serve 14, then 15 and 0 together
    do_reset();
    bus.mie_i = 32'hFFFF;
    bus.irq_i = 16'h4000;
    step();
    bus.irq_i = '0;
    step();
    ack_now();
    step();
`ifdef IRQ_ROUND_ROBIN_EN
    first_line  = 15;
    second_line = 0;
`else
    first_line  = 0;
    second_line = 15;
`endif
    bus.irq_i = 16'h8001;
    step();
    bus.irq_i = '0;
    step();
    check_eq("wrap_first", bus.mcause_o, 32'h8000_0010 + 32'(first_line));
    ack_now();
    step();
    check_eq("wrap_second", bus.mcause_o, 32'h8000_0010 + 32'(second_line));
    ack_now();
    step();
    $display("wrap 15/0 done");

    // Random traffic
    do_reset();
    bus.mie_i = 32'hFFFF;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(7) == 0) bus.irq_i[k] = ~bus.irq_i[k];
      end
      if ($urandom_range(49) == 0) begin
        bus.mie_i = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      bus.int_rst_i = ($urandom_range(3) == 0);
      step();
    end
    bus.int_rst_i = 1'b0;
    $display("random traffic done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
